// File: rtl/game_timer.sv
// Round countdown timer: two BCD digits of remaining seconds, a 1 s tick,
// a low-time warning and a timeout level that ends gameplay.
module game_timer #(
    parameter int unsigned TICK_DIV     = 50_000_000,
    parameter logic [3:0]  DEFAULT_TENS = 4'd5,
    parameter logic [3:0]  DEFAULT_ONES = 4'd9,
    parameter logic [6:0]  LOW_THRESH   = 7'd10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       reconfig,
    input  logic       timer_enable,
    input  logic [3:0] cfg_tens,
    input  logic [3:0] cfg_ones,
    output logic       timeout,
    output logic [3:0] time_tens,
    output logic [3:0] time_ones,
    output logic       running,
    output logic       sec_tick,
    output logic       low_time
);

    localparam int unsigned    PSC_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOADED,
        RUN,
        PAUSE,
        EXPIRED
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [PSC_W-1:0] psc;
    logic [PSC_W-1:0] psc_next;
    logic [3:0]       tens_next;
    logic [3:0]       ones_next;
    logic             timeout_next;
    logic             running_next;
    logic             sec_tick_next;
    logic             low_time_next;
    logic [6:0]       remain_next;

    logic             tick;
    logic             cfg_bad;
    logic [3:0]       load_tens;
    logic [3:0]       load_ones;
    logic [3:0]       dec_tens;
    logic [3:0]       dec_ones;
    logic             dec_zero;

    assign tick      = (state == RUN) && (psc == PSC_MAX);
    assign cfg_bad   = (cfg_tens > 4'd9) || (cfg_ones > 4'd9) ||
                       ((cfg_tens == 4'd0) && (cfg_ones == 4'd0));
    assign load_tens = cfg_bad ? DEFAULT_TENS : cfg_tens;
    assign load_ones = cfg_bad ? DEFAULT_ONES : cfg_ones;

    // BCD decrement with borrow; saturates at 00
    always_comb begin
        dec_tens = time_tens;
        dec_ones = time_ones;
        if (time_ones == 4'd0) begin
            if (time_tens != 4'd0) begin
                dec_ones = 4'd9;
                dec_tens = time_tens - 4'd1;
            end
        end else begin
            dec_ones = time_ones - 4'd1;
        end
    end

    assign dec_zero = (dec_tens == 4'd0) && (dec_ones == 4'd0);

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            psc       <= '0;
            time_tens <= 4'd0;
            time_ones <= 4'd0;
            timeout   <= 1'b0;
            running   <= 1'b0;
            sec_tick  <= 1'b0;
            low_time  <= 1'b0;
        end else begin
            state     <= state_next;
            psc       <= psc_next;
            time_tens <= tens_next;
            time_ones <= ones_next;
            timeout   <= timeout_next;
            running   <= running_next;
            sec_tick  <= sec_tick_next;
            low_time  <= low_time_next;
        end
    end

    // Next-state logic; reconfig overrides every state
    always_comb begin
        state_next = state;
        if (reconfig) begin
            state_next = LOADED;
        end else begin
            case (state)
                IDLE:    state_next = IDLE;
                LOADED:  if (timer_enable) state_next = RUN;
                RUN: begin
                    if (tick) begin
                        if (dec_zero) state_next = EXPIRED;
                    end else if (!timer_enable) begin
                        state_next = PAUSE;
                    end
                end
                PAUSE:   if (timer_enable) state_next = RUN;
                EXPIRED: state_next = EXPIRED;
                default: state_next = IDLE;
            endcase
        end
    end

    // Datapath and output next values
    always_comb begin
        psc_next      = psc;
        tens_next     = time_tens;
        ones_next     = time_ones;
        sec_tick_next = 1'b0;
        if (reconfig) begin
            psc_next  = '0;
            tens_next = load_tens;
            ones_next = load_ones;
        end else begin
            case (state)
                IDLE, EXPIRED: begin
                    tens_next = 4'd0;
                    ones_next = 4'd0;
                end
                RUN: begin
                    if (tick) begin
                        psc_next      = '0;
                        tens_next     = dec_tens;
                        ones_next     = dec_ones;
                        sec_tick_next = 1'b1;
                    end else if (timer_enable) begin
                        psc_next = psc + PSC_W'(1);
                    end
                end
                default: ;
            endcase
        end
        timeout_next  = (state_next == EXPIRED);
        running_next  = (state_next == RUN);
        remain_next   = 7'(tens_next) * 7'd10 + 7'(ones_next);
        low_time_next = running_next && (remain_next <= LOW_THRESH);
    end

endmodule

// File: tb/tb_game_timer.sv
// Scoreboard bench for game_timer with TICK_DIV=4: expected output vectors
// are queued with each stimulus cycle and compared after the clock edge.
module tb_game_timer;

    logic       clk;
    logic       rst;
    logic       reconfig;
    logic       timer_enable;
    logic [3:0] cfg_tens;
    logic [3:0] cfg_ones;
    logic       timeout;
    logic [3:0] time_tens;
    logic [3:0] time_ones;
    logic       running;
    logic       sec_tick;
    logic       low_time;

    int checks = 0;
    int errors = 0;

    string      tag_q[$];
    logic [11:0] exp_q[$];

    game_timer #(
        .TICK_DIV    (4),
        .DEFAULT_TENS(4'd5),
        .DEFAULT_ONES(4'd9),
        .LOW_THRESH  (7'd10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .reconfig    (reconfig),
        .timer_enable(timer_enable),
        .cfg_tens    (cfg_tens),
        .cfg_ones    (cfg_ones),
        .timeout     (timeout),
        .time_tens   (time_tens),
        .time_ones   (time_ones),
        .running     (running),
        .sec_tick    (sec_tick),
        .low_time    (low_time)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {timeout, tens, ones, running, sec_tick, low_time}
    function automatic logic [11:0] ev(input logic to, input logic [3:0] t, input logic [3:0] o,
                                       input logic r, input logic s, input logic l);
        return {to, t, o, r, s, l};
    endfunction

    function automatic logic [11:0] observed();
        return {timeout, time_tens, time_ones, running, sec_tick, low_time};
    endfunction

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Queue the expectation for the edge about to happen, then compare it
    task automatic step(input string tag, input logic [11:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
        cyc();
        if (exp_q.size() == 0) begin
            check("sb_empty", 12'd1, 12'd0);
        end else begin
            check(tag_q.pop_front(), observed(), exp_q.pop_front());
        end
    endtask

    task automatic pulse_reconfig(input string tag, input logic [3:0] t, input logic [3:0] o,
                                  input logic [11:0] exp);
        cfg_tens = t;
        cfg_ones = o;
        reconfig = 1'b1;
        step(tag, exp);
        reconfig = 1'b0;
    endtask

    initial begin
        int rc;
        int ticks;
        rst          = 1'b0;
        reconfig     = 1'b0;
        timer_enable = 1'b0;
        cfg_tens     = 4'd0;
        cfg_ones     = 4'd0;

        // Reset and IDLE ignoring enable
        cyc();
        step("reset", ev(0, 0, 0, 0, 0, 0));
        rst = 1'b1;
        timer_enable = 1'b1;
        step("idle_ignore_en", ev(0, 0, 0, 0, 0, 0));
        timer_enable = 1'b0;

        // Count 12 down to expiry
        pulse_reconfig("load_12", 4'd1, 4'd2, ev(0, 1, 2, 0, 0, 0));
        timer_enable = 1'b1;
        step("run_enter", ev(0, 1, 2, 1, 0, 0));
        for (int i = 0; i < 3; i++) step("run_12", ev(0, 1, 2, 1, 0, 0));
        step("first_dec_11", ev(0, 1, 1, 1, 1, 0));
        rc = 4;
        ticks = 1;
        while (!timeout && rc < 200) begin
            cyc();
            rc++;
            if (sec_tick) ticks++;
        end
        check("run_cycles", 12'(rc), 12'd48);
        check("tick_count", 12'(ticks), 12'd12);
        check("expire", observed(), ev(1, 0, 0, 0, 1, 0));
        step("expired_hold", ev(1, 0, 0, 0, 0, 0));

        // Reconfig in EXPIRED with enable high lands in LOADED; then borrow 20 -> 19
        pulse_reconfig("reload_20", 4'd2, 4'd0, ev(0, 2, 0, 0, 0, 0));
        step("run_20", ev(0, 2, 0, 1, 0, 0));
        for (int i = 0; i < 3; i++) step("run_20b", ev(0, 2, 0, 1, 0, 0));
        step("borrow_19", ev(0, 1, 9, 1, 1, 0));

        // Pause with prescaler at 2, resume keeps the partial second
        step("psc1", ev(0, 1, 9, 1, 0, 0));
        step("psc2", ev(0, 1, 9, 1, 0, 0));
        timer_enable = 1'b0;
        for (int i = 0; i < 10; i++) step("paused", ev(0, 1, 9, 0, 0, 0));
        timer_enable = 1'b1;
        step("resume", ev(0, 1, 9, 1, 0, 0));
        step("resume_psc3", ev(0, 1, 9, 1, 0, 0));
        step("resume_dec_18", ev(0, 1, 8, 1, 1, 0));

        // Reset mid-run
        rst = 1'b0;
        step("rst_mid_run", ev(0, 0, 0, 0, 0, 0));
        rst = 1'b1;
        step("idle_after_rst", ev(0, 0, 0, 0, 0, 0));

        // Low-time threshold at 10
        pulse_reconfig("load_11", 4'd1, 4'd1, ev(0, 1, 1, 0, 0, 0));
        step("run_11", ev(0, 1, 1, 1, 0, 0));
        for (int i = 0; i < 3; i++) step("run_11b", ev(0, 1, 1, 1, 0, 0));
        step("low_on_10", ev(0, 1, 0, 1, 1, 1));
        step("low_hold", ev(0, 1, 0, 1, 0, 1));

        // Load rule: invalid or zero configs take the default
        timer_enable = 1'b0;
        pulse_reconfig("cfg_A3", 4'hA, 4'd3, ev(0, 5, 9, 0, 0, 0));
        pulse_reconfig("cfg_3A", 4'd3, 4'hA, ev(0, 5, 9, 0, 0, 0));
        pulse_reconfig("cfg_00", 4'd0, 4'd0, ev(0, 5, 9, 0, 0, 0));
        pulse_reconfig("cfg_99", 4'd9, 4'd9, ev(0, 9, 9, 0, 0, 0));
        pulse_reconfig("cfg_05", 4'd0, 4'd5, ev(0, 0, 5, 0, 0, 0));
        timer_enable = 1'b1;
        step("run_05_low", ev(0, 0, 5, 1, 0, 1));

        check("sb_drained", 12'(exp_q.size()), 12'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
